// File: rtl/pcs_tx_gearbox.sv
// ---------------------------------------------------------------------------
// pcs_tx_gearbox
//
// 10GBASE-R PCS transmit gearbox. It joins the 2-bit sync header with the
// 64-bit scrambled payload to form a 66-bit block. It then repacks the block
// stream into a continuous stream of 64-bit words for the SerDes. After every
// 32 accepted blocks the gearbox spends one cycle draining its 64-bit residue,
// and data_in_ready is low during that cycle.
//
// Ports:
//   clk            single clock domain
//   rst            synchronous, active-low reset
//   header_in      sync header, bit 0 transmitted first
//   data_in        scrambled payload, bit 0 transmitted right after header bit 1
//   data_in_valid  header_in/data_in hold a block
//   data_in_ready  block is taken when data_in_valid && data_in_ready (registered)
//   data_out       serial-order word, bit 0 first on the line (registered)
//   data_out_valid data_out holds a new word (registered)
//   hdr_err        one-cycle pulse after accepting a block with header 00/11
//                  (only when PCS_TX_HDR_CHECK_EN is defined)
//
// Optional feature macro: PCS_TX_HDR_CHECK_EN (header validity check).
// DATA_WIDTH must be 64; the 33-slot period is tied to the 66/64 ratio.
// ---------------------------------------------------------------------------
module pcs_tx_gearbox #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            header_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid
`ifdef PCS_TX_HDR_CHECK_EN
  ,
  output logic                  hdr_err
`endif
);

  localparam int BLK_W = DATA_WIDTH + 2;
  localparam int BUF_W = 2 * DATA_WIDTH;
  // Slot 32 is the drain slot. Slots 0..31 each accept one block.
  localparam logic [5:0] DRAIN_SLOT = 6'd32;

  logic [5:0]            seq_r;
  logic [6:0]            fill_r;
  logic [BUF_W-1:0]      buf_r;

  logic [BLK_W-1:0]      blk_s;
  logic [BUF_W-1:0]      cat_s;
  logic                  drain_s;
  logic                  accept_s;
  logic [5:0]            seq_next_s;
  logic [6:0]            fill_next_s;
  logic [BUF_W-1:0]      buf_next_s;
  logic [DATA_WIDTH-1:0] out_next_s;
  logic                  out_valid_next_s;

  // Next-state logic: the slot type (drain, accept, stall) determines the update.
  always_comb begin
    blk_s    = {data_in, header_in};
    // buf_r is zero above fill_r, so OR-ing the shifted block appends it to the stream.
    cat_s    = buf_r | ({{(BUF_W-BLK_W){1'b0}}, blk_s} << fill_r);
    drain_s  = (seq_r == DRAIN_SLOT);
    accept_s = data_in_valid && data_in_ready && !drain_s;

    seq_next_s       = seq_r;
    fill_next_s      = fill_r;
    buf_next_s       = buf_r;
    out_next_s       = data_out;
    out_valid_next_s = 1'b0;

    if (drain_s) begin
      // After 32 blocks, fill is exactly 64. Emit the full residue and realign.
      out_next_s       = buf_r[DATA_WIDTH-1:0];
      out_valid_next_s = 1'b1;
      seq_next_s       = 6'd0;
      fill_next_s      = 7'd0;
      buf_next_s       = {BUF_W{1'b0}};
    end else if (accept_s) begin
      out_next_s       = cat_s[DATA_WIDTH-1:0];
      out_valid_next_s = 1'b1;
      seq_next_s       = seq_r + 6'd1;
      fill_next_s      = fill_r + 7'd2;
      buf_next_s       = cat_s >> DATA_WIDTH;
    end else begin
      // Stall: hold the residue. data_out keeps its last word, marked invalid.
      out_valid_next_s = 1'b0;
    end
  end

  // State and output registers. data_in_ready looks one slot ahead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      seq_r          <= 6'd0;
      fill_r         <= 7'd0;
      buf_r          <= {BUF_W{1'b0}};
      data_out       <= {DATA_WIDTH{1'b0}};
      data_out_valid <= 1'b0;
      data_in_ready  <= 1'b0;
    end else begin
      seq_r          <= seq_next_s;
      fill_r         <= fill_next_s;
      buf_r          <= buf_next_s;
      data_out       <= out_next_s;
      data_out_valid <= out_valid_next_s;
      data_in_ready  <= (seq_next_s != DRAIN_SLOT);
    end
  end

`ifdef PCS_TX_HDR_CHECK_EN
  // Only 01 and 10 are legal sync headers.
  function automatic logic hdr_invalid(input logic [1:0] hdr);
    return (hdr == 2'b00) || (hdr == 2'b11);
  endfunction

  // Header check flag: one-cycle pulse for each accepted block with a bad header.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hdr_err <= 1'b0;
    end else begin
      hdr_err <= accept_s && hdr_invalid(header_in);
    end
  end
`endif

endmodule

// File: tb/tb_pcs_tx_gearbox.sv
// ---------------------------------------------------------------------------
// tb_pcs_tx_gearbox
//
// Directed, self-checking bench for pcs_tx_gearbox. The header-check scenario
// is compiled only when PCS_TX_HDR_CHECK_EN is defined.
// ---------------------------------------------------------------------------
module tb_pcs_tx_gearbox;

  logic        clk;
  logic        rst;
  logic [1:0]  header_in;
  logic [63:0] data_in;
  logic        data_in_valid;
  logic        data_in_ready;
  logic [63:0] data_out;
  logic        data_out_valid;
`ifdef PCS_TX_HDR_CHECK_EN
  logic        hdr_err;
`endif

  int n_cmp;
  int n_err;

  // Logs filled by run_stream. Index = cycle (or output word) number.
  logic        rdy_log   [0:255];
  logic        rdy_exp   [0:255];
  logic        stall_log [0:255];
  logic        vout_log  [0:255];
  logic [63:0] word_log  [0:255];
  int          n_cyc;
  int          n_words;

  pcs_tx_gearbox #(.DATA_WIDTH(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .header_in      (header_in),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid)
`ifdef PCS_TX_HDR_CHECK_EN
    ,
    .hdr_err        (hdr_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge. Outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    data_in_valid = 1'b0;
    header_in = 2'b00;
    data_in = 64'd0;
    step();
    step();
    rst = 1'b1;
  endtask

  // Stream block j used by the continuous and stall scenarios.
  function automatic logic [65:0] stream_blk(input int j);
    return {32'hA5A5A5A5, 32'(j), 2'b01};
  endfunction

  // Expected output word w: bits 64w..64w+63 of the serial block stream.
  function automatic logic [63:0] exp_word(input int w);
    logic [63:0] r;
    logic [65:0] b;
    int k;
    for (int i = 0; i < 64; i++) begin
      k = 64 * w + i;
      b = stream_blk(k / 66);
      r[i] = b[k % 66];
    end
    return r;
  endfunction

  // Drive 64 stream blocks and record ready, valid and output words. This task
  // only drives and records; the scenario tasks do the comparisons.
  task automatic run_stream(input bit do_stall);
    int nblk;
    int acc;
    int st10;
    int st31;
    logic stall;
    logic took;
    nblk = 0; acc = 0; st10 = 0; st31 = 0;
    n_cyc = 0; n_words = 0;
    reset_dut();
    step();  // release edge; data_in_ready rises
    while (n_words < 66 && n_cyc < 200) begin
      stall = do_stall && nblk < 32 &&
              ((acc == 10 && st10 < 3) || (acc == 31 && st31 < 1));
      if (stall && acc == 10) st10++;
      if (stall && acc == 31) st31++;
      data_in_valid = !stall && (nblk < 64);
      header_in = 2'b01;
      data_in = {32'hA5A5A5A5, 32'(nblk)};
      rdy_log[n_cyc]   = data_in_ready;
      rdy_exp[n_cyc]   = (acc != 32);
      stall_log[n_cyc] = stall;
      took = data_in_valid && data_in_ready;
      step();
      if (acc == 32) acc = 0;
      else if (took) acc++;
      if (took) nblk++;
      vout_log[n_cyc] = data_out_valid;
      if (data_out_valid) begin
        word_log[n_words] = data_out;
        n_words++;
      end
      n_cyc++;
    end
    data_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      header_in = 2'($urandom_range(0, 3));
      data_in = {$urandom, $urandom};
      data_in_valid = 1'($urandom_range(0, 1));
      step();
      n_cmp++;
      if (data_out !== 64'd0 || data_out_valid !== 1'b0 || data_in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold cyc=%0d: out=%h vld=%b rdy=%b, required 0/0/0",
                 i, data_out, data_out_valid, data_in_ready);
      end
    end
    rst = 1'b1;
    data_in_valid = 1'b0;
    step();
    n_cmp++;
    if (data_in_ready !== 1'b1 || data_out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: rdy=%b vld=%b, required 1/0", data_in_ready, data_out_valid);
    end
  endtask

  task automatic test_continuous();
    run_stream(1'b0);
    n_cmp++;
    if (n_cyc !== 66 || n_words !== 66) begin
      n_err++;
      $display("FAIL cont_length: cycles=%0d words=%0d, required 66/66", n_cyc, n_words);
    end
    for (int c = 0; c < n_cyc && c < 66; c++) begin
      n_cmp++;
      if (rdy_log[c] !== ((c + 1) % 33 != 0)) begin
        n_err++;
        $display("FAIL cont_ready cyc=%0d: got %b, required %b", c + 1, rdy_log[c], ((c + 1) % 33 != 0));
      end
      n_cmp++;
      if (vout_log[c] !== 1'b1) begin
        n_err++;
        $display("FAIL cont_valid cyc=%0d: got %b, required 1", c + 1, vout_log[c]);
      end
    end
    for (int w = 0; w < n_words; w++) begin
      n_cmp++;
      if (word_log[w] !== exp_word(w)) begin
        n_err++;
        $display("FAIL cont_word %0d: got %h, required %h", w, word_log[w], exp_word(w));
      end
    end
  endtask

  task automatic test_stall();
    run_stream(1'b1);
    n_cmp++;
    if (n_cyc !== 70 || n_words !== 66) begin
      n_err++;
      $display("FAIL stall_length: cycles=%0d words=%0d, required 70/66", n_cyc, n_words);
    end
    for (int c = 0; c < n_cyc; c++) begin
      n_cmp++;
      if (rdy_log[c] !== rdy_exp[c]) begin
        n_err++;
        $display("FAIL stall_ready cyc=%0d: got %b, required %b", c + 1, rdy_log[c], rdy_exp[c]);
      end
      n_cmp++;
      if (vout_log[c] !== !stall_log[c]) begin
        n_err++;
        $display("FAIL stall_valid cyc=%0d: got %b, required %b", c + 1, vout_log[c], !stall_log[c]);
      end
    end
    for (int w = 0; w < n_words; w++) begin
      n_cmp++;
      if (word_log[w] !== exp_word(w)) begin
        n_err++;
        $display("FAIL stall_word %0d: got %h, required %h", w, word_log[w], exp_word(w));
      end
    end
  endtask

  task automatic test_realign();
    reset_dut();
    step();
    for (int i = 0; i < 32; i++) begin
      data_in_valid = 1'b1;
      header_in = 2'b01;
      data_in = {32'hA5A5A5A5, 32'(i)};
      step();
    end
    // Offer block 33 during the drain slot; it must wait.
    header_in = 2'b10;
    data_in = 64'h0123456789ABCDEF;
    n_cmp++;
    if (data_in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL realign_ready_low: got %b, required 0", data_in_ready);
    end
    step();
    n_cmp++;
    if (data_out !== 64'hA5A5A5A5_0000001F || data_out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL realign_drain: got %h vld=%b, required a5a5a5a50000001f vld=1",
               data_out, data_out_valid);
    end
    n_cmp++;
    if (data_in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL realign_ready_high: got %b, required 1", data_in_ready);
    end
    step();
    data_in_valid = 1'b0;
    n_cmp++;
    if (data_out !== 64'h048D159E26AF37BE || data_out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL realign_word: got %h vld=%b, required 048d159e26af37be vld=1",
               data_out, data_out_valid);
    end
  endtask

  task automatic test_mid_reset();
    reset_dut();
    step();
    for (int i = 0; i < 17; i++) begin
      data_in_valid = 1'b1;
      header_in = 2'b10;
      data_in = {$urandom, $urandom};
      step();
    end
    rst = 1'b0;
    data_in_valid = 1'b0;
    step();
    n_cmp++;
    if (data_out !== 64'd0 || data_out_valid !== 1'b0 || data_in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_state: out=%h vld=%b rdy=%b, required 0/0/0",
               data_out, data_out_valid, data_in_ready);
    end
    rst = 1'b1;
    data_in_valid = 1'b1;
    header_in = 2'b01;
    data_in = 64'hFFFF0000FFFF0000;
    step();
    n_cmp++;
    if (data_in_ready !== 1'b1 || data_out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_release: rdy=%b vld=%b, required 1/0", data_in_ready, data_out_valid);
    end
    step();
    data_in_valid = 1'b0;
    n_cmp++;
    if (data_out !== 64'hFFFC0003FFFC0001 || data_out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_word: got %h vld=%b, required fffc0003fffc0001 vld=1",
               data_out, data_out_valid);
    end
  endtask

`ifdef PCS_TX_HDR_CHECK_EN
  task automatic test_hdr_check();
    logic [1:0]  hdrs [0:3];
    logic        err_exp [0:3];
    logic [63:0] word_exp [0:3];
    hdrs[0] = 2'b01; hdrs[1] = 2'b00; hdrs[2] = 2'b10; hdrs[3] = 2'b11;
    err_exp[0] = 1'b0; err_exp[1] = 1'b1; err_exp[2] = 1'b0; err_exp[3] = 1'b1;
    // Zero payloads, so word k is just header k shifted by the 2k-bit residue offset.
    word_exp[0] = 64'h1; word_exp[1] = 64'h0; word_exp[2] = 64'h20; word_exp[3] = 64'hC0;
    reset_dut();
    step();
    for (int i = 0; i < 4; i++) begin
      data_in_valid = 1'b1;
      header_in = hdrs[i];
      data_in = 64'd0;
      step();
      n_cmp++;
      if (hdr_err !== err_exp[i] || data_out !== word_exp[i]) begin
        n_err++;
        $display("FAIL hdr_check blk=%0d: err=%b out=%h, required err=%b out=%h",
                 i, hdr_err, data_out, err_exp[i], word_exp[i]);
      end
    end
    data_in_valid = 1'b0;
    step();
    n_cmp++;
    if (hdr_err !== 1'b0) begin
      n_err++;
      $display("FAIL hdr_check_clear: err=%b, required 0", hdr_err);
    end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    header_in = 2'b00;
    data_in = 64'd0;
    data_in_valid = 1'b0;
    test_reset();
    test_continuous();
    test_stall();
    test_realign();
    test_mid_reset();
`ifdef PCS_TX_HDR_CHECK_EN
    test_hdr_check();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
